// File: rtl/roberto.sv
`default_nettype none
// roberto: three-channel sonar ranging controller; echo widths are rounded to cm and reported as a 7E1 ASCII frame.
// Optional macro RX_PARITY_CHECK_EN: drop received command characters whose even parity is wrong. Rev 1.0
module roberto #(
    parameter int CLK_PER_CM   = 2941,
    parameter int TRIG_CLKS    = 500,
    parameter int TIMEOUT_CLKS = 1500000,
    parameter int BAUD_DIV     = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic ligar,
    input  logic echo1,
    input  logic echo2,
    input  logic echo3,
    input  logic RX,
    output logic trigger1,
    output logic trigger2,
    output logic trigger3,
    output logic saida_serial,
    output logic pronto
);

    localparam int c_cnt_max = (TIMEOUT_CLKS > TRIG_CLKS) ? TIMEOUT_CLKS : TRIG_CLKS;
    localparam int c_cw      = $clog2(c_cnt_max + 1);
    localparam int c_sw      = $clog2(CLK_PER_CM + 1);
    localparam int c_bw      = $clog2(BAUD_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TRIG = 3'd1,
        S_WAIT = 3'd2,
        S_TX   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                   state_q;
    logic [c_cw-1:0]          cnt_q;
    logic                     trig_q;
    logic                     serial_q;
    logic                     pronto_q;
    logic [2:0]               started_q;
    logic [2:0]               done_q;
    logic [2:0][c_sw-1:0]     sub_q;
    logic [2:0][11:0]         dist_q;
    logic [3:0]               char_q;
    logic [3:0]               bit_q;
    logic [c_bw-1:0]          baud_q;
    logic [2:0]               echo_m_q;
    logic [2:0]               echo_s_q;
    logic                     pend_q;
    logic                     pend_d;
    logic                     rx_cmd_q;
    logic [6:0]               w_char;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] char_at(input logic [3:0] idx, input logic [2:0][11:0] d);
        logic [6:0] c;
        case (idx)
            4'd0:    c = {3'b011, d[0][11:8]};
            4'd1:    c = {3'b011, d[0][7:4]};
            4'd2:    c = {3'b011, d[0][3:0]};
            4'd3:    c = 7'h2C;
            4'd4:    c = {3'b011, d[1][11:8]};
            4'd5:    c = {3'b011, d[1][7:4]};
            4'd6:    c = {3'b011, d[1][3:0]};
            4'd7:    c = 7'h2C;
            4'd8:    c = {3'b011, d[2][11:8]};
            4'd9:    c = {3'b011, d[2][7:4]};
            4'd10:   c = {3'b011, d[2][3:0]};
            default: c = 7'h23;
        endcase
        return c;
    endfunction

    // Bit 0 start, 1..7 data LSB first, 8 even parity, 9 stop.
    function automatic logic tx_bit(input logic [6:0] ch, input logic [3:0] idx);
        logic b;
        b = 1'b1;
        if (idx == 4'd0) begin
            b = 1'b0;
        end else if (idx <= 4'd7) begin
            b = ch[3'(idx - 4'd1)];
        end else if (idx == 4'd8) begin
            b = ^ch;
        end
        return b;
    endfunction

    assign w_char = char_at(char_q, dist_q);
    assign pend_d = (pend_q && (state_q != S_IDLE)) || ligar || rx_cmd_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_m_q <= '0;
            echo_s_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            echo_m_q <= {echo3, echo2, echo1};
            echo_s_q <= echo_m_q;
            pend_q   <= pend_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            trig_q    <= 1'b0;
            serial_q  <= 1'b1;
            pronto_q  <= 1'b0;
            started_q <= '0;
            done_q    <= '0;
            sub_q     <= '0;
            dist_q    <= '0;
            char_q    <= '0;
            bit_q     <= '0;
            baud_q    <= '0;
        end else begin
            pronto_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        state_q   <= S_TRIG;
                        trig_q    <= 1'b1;
                        cnt_q     <= '0;
                        started_q <= '0;
                        done_q    <= '0;
                        for (int i = 0; i < 3; i++) begin
                            sub_q[i]  <= c_sw'(CLK_PER_CM / 2);
                            dist_q[i] <= '0;
                        end
                    end
                end
                S_TRIG: begin
                    if (cnt_q == c_cw'(TRIG_CLKS - 1)) begin
                        state_q <= S_WAIT;
                        trig_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if ((&done_q) || (cnt_q == c_cw'(TIMEOUT_CLKS - 1))) begin
                        for (int i = 0; i < 3; i++) begin
                            if (!done_q[i]) dist_q[i] <= 12'h999;
                        end
                        state_q  <= S_TX;
                        serial_q <= 1'b0;
                        char_q   <= '0;
                        bit_q    <= '0;
                        baud_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        // Sub-counter starts at half a cm so the wrap count rounds to nearest.
                        for (int i = 0; i < 3; i++) begin
                            if (!done_q[i]) begin
                                if (echo_s_q[i]) begin
                                    started_q[i] <= 1'b1;
                                    if (sub_q[i] == c_sw'(CLK_PER_CM - 1)) begin
                                        sub_q[i]  <= '0;
                                        dist_q[i] <= bcd_inc(dist_q[i]);
                                    end else begin
                                        sub_q[i] <= sub_q[i] + 1'b1;
                                    end
                                end else if (started_q[i]) begin
                                    done_q[i] <= 1'b1;
                                end
                            end
                        end
                    end
                end
                S_TX: begin
                    if (baud_q == c_bw'(BAUD_DIV - 1)) begin
                        baud_q <= '0;
                        if (bit_q == 4'd9) begin
                            if (char_q == 4'd11) begin
                                state_q  <= S_DONE;
                                pronto_q <= 1'b1;
                                serial_q <= 1'b1;
                            end else begin
                                char_q   <= char_q + 4'd1;
                                bit_q    <= '0;
                                serial_q <= 1'b0;
                            end
                        end else begin
                            bit_q    <= bit_q + 4'd1;
                            serial_q <= tx_bit(w_char, bit_q + 4'd1);
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic            rx_m_q;
    logic            rx_s_q;
    logic            rx_prev_q;
    logic            rx_busy_q;
    logic [c_bw-1:0] rx_cnt_q;
    logic [3:0]      rx_bit_q;
    logic [6:0]      rx_data_q;
    logic            w_par_ok;

`ifdef RX_PARITY_CHECK_EN
    logic rx_par_q;
    assign w_par_ok = (rx_par_q == ^rx_data_q);
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_m_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_busy_q <= 1'b0;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_data_q <= '0;
            rx_cmd_q  <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            rx_par_q  <= 1'b0;
`endif
        end else begin
            rx_m_q    <= RX;
            rx_s_q    <= rx_m_q;
            rx_prev_q <= rx_s_q;
            rx_cmd_q  <= 1'b0;
            if (!rx_busy_q) begin
                if (rx_prev_q && !rx_s_q) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= '0;
                    rx_bit_q  <= '0;
                end
            end else begin
                if (rx_cnt_q == c_bw'(BAUD_DIV - 1)) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= rx_bit_q + 4'd1;
                end else begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                end
                if (rx_cnt_q == c_bw'(BAUD_DIV / 2)) begin
                    if (rx_bit_q == 4'd0) begin
                        if (rx_s_q) rx_busy_q <= 1'b0;
                    end else if (rx_bit_q <= 4'd7) begin
                        rx_data_q <= {rx_s_q, rx_data_q[6:1]};
                    end else if (rx_bit_q == 4'd8) begin
`ifdef RX_PARITY_CHECK_EN
                        rx_par_q <= rx_s_q;
`endif
                    end else begin
                        rx_busy_q <= 1'b0;
                        if (rx_s_q && w_par_ok && (rx_data_q == 7'h4C)) rx_cmd_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign trigger1     = trig_q;
    assign trigger2     = trig_q;
    assign trigger3     = trig_q;
    assign saida_serial = serial_q;
    assign pronto       = pronto_q;

endmodule
`default_nettype wire

// File: tb/tb_roberto.sv
`default_nettype none
// tb_roberto: randomized bench for roberto; expected frames come from cm = round(width / CLK_PER_CM), saturated at 999.
module tb_roberto;
    localparam int CPM  = 4;
    localparam int TRIG = 10;
    localparam int TMO  = 5000;
    localparam int BAUD = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ligar = 1'b0;
    logic echo1 = 1'b0;
    logic echo2 = 1'b0;
    logic echo3 = 1'b0;
    logic RX    = 1'b1;
    logic trigger1, trigger2, trigger3, saida_serial, pronto;

    int n_tests = 0;
    int n_fail  = 0;
    int dly[3];
    int wid[3];     // 0: no echo, -1: echo stuck high, >0: echo width in clocks
    bit pre_hi = 1'b0;
    int t;

    roberto #(
        .CLK_PER_CM  (CPM),
        .TRIG_CLKS   (TRIG),
        .TIMEOUT_CLKS(TMO),
        .BAUD_DIV    (BAUD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ligar       (ligar),
        .echo1       (echo1),
        .echo2       (echo2),
        .echo3       (echo3),
        .RX          (RX),
        .trigger1    (trigger1),
        .trigger2    (trigger2),
        .trigger3    (trigger3),
        .saida_serial(saida_serial),
        .pronto      (pronto)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no summary, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_cm(input int w);
        int cm;
        if (w <= 0) return 999;
        cm = (w + CPM / 2) / CPM;
        return (cm > 999) ? 999 : cm;
    endfunction

    function automatic logic [95:0] exp_frame();
        logic [95:0] f;
        int cm;
        f = '0;
        for (int c = 0; c < 3; c++) begin
            cm = exp_cm(wid[c]);
            f = {f[87:0], 8'h30 + 8'(cm / 100)};
            f = {f[87:0], 8'h30 + 8'((cm / 10) % 10)};
            f = {f[87:0], 8'h30 + 8'(cm % 10)};
            f = {f[87:0], (c == 2) ? 8'h23 : 8'h2C};
        end
        return f;
    endfunction

    task automatic set_echo(input int ch, input logic v);
        case (ch)
            0:       echo1 = v;
            1:       echo2 = v;
            default: echo3 = v;
        endcase
    endtask

    task automatic clear_echoes();
        echo1 = 1'b0;
        echo2 = 1'b0;
        echo3 = 1'b0;
        pre_hi = 1'b0;
    endtask

    task automatic set_cfg(input int w0, input int w1, input int w2, input int d0, input int d1, input int d2);
        wid[0] = w0; wid[1] = w1; wid[2] = w2;
        dly[0] = d0; dly[1] = d1; dly[2] = d2;
    endtask

    task automatic set_rand();
        for (int c = 0; c < 3; c++) begin
            int k;
            k = int'($urandom_range(0, 9));
            dly[c] = int'($urandom_range(1, 200));
            if (k == 0)      wid[c] = 0;
            else if (k == 1) wid[c] = -1;
            else if (k == 2) wid[c] = int'($urandom_range(4000, 4300));
            else             wid[c] = int'($urandom_range(1, 1500));
        end
    endtask

    task automatic send_rx(input logic [6:0] d, input bit bad);
        logic [9:0] fr;
        fr = {1'b1, (^d) ^ bad, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = fr[i];
            repeat (BAUD) @(negedge clock);
        end
        RX = 1'b1;
    endtask

    task automatic start_meas(input int mode, input int bound, input string tag);
        int n;
        int w;
        bit mism;
        if (mode == 0) begin
            @(negedge clock);
            ligar = 1'b1;
            @(negedge clock);
            ligar = 1'b0;
        end else if (mode == 1) begin
            fork
                send_rx(7'h4C, 1'b0);
            join_none
        end
        n = 0;
        while (trigger1 !== 1'b1 && n < bound) begin
            @(negedge clock);
            n++;
        end
        check_val($sformatf("%s_start", tag), 128'(trigger1), 128'(1));
        w = 0;
        mism = 1'b0;
        while (trigger1 === 1'b1 && w < TRIG + 50) begin
            if (trigger2 !== 1'b1 || trigger3 !== 1'b1) mism = 1'b1;
            w++;
            @(negedge clock);
        end
        check_val($sformatf("%s_trig_w", tag), 128'(w), 128'(TRIG));
        check_val($sformatf("%s_trig_all", tag), 128'(mism), 128'(0));
    endtask

    task automatic drive_one(input int ch);
        if (ch == 0 && pre_hi) begin
            repeat (wid[0]) @(negedge clock);
            set_echo(0, 1'b0);
        end else if (wid[ch] == -1) begin
            repeat (dly[ch]) @(negedge clock);
            set_echo(ch, 1'b1);
        end else if (wid[ch] > 0) begin
            repeat (dly[ch]) @(negedge clock);
            set_echo(ch, 1'b1);
            repeat (wid[ch]) @(negedge clock);
            set_echo(ch, 1'b0);
        end
    endtask

    task automatic drive_echoes();
        fork
            drive_one(0);
            drive_one(1);
            drive_one(2);
        join
    endtask

    task automatic get_frame(input string tag);
        logic [95:0] f;
        logic [6:0]  d;
        logic        p;
        logic        s;
        int          errs;
        int          n;
        bit          lost;
        f = '0; d = '0; errs = 0; lost = 1'b0;
        for (int k = 0; k < 12 && !lost; k++) begin
            n = 0;
            while (saida_serial !== 1'b0 && n < TMO + 200) begin
                @(negedge clock);
                n++;
            end
            if (saida_serial !== 1'b0) begin
                lost = 1'b1;
            end else begin
                repeat (BAUD / 2) @(negedge clock);
                if (saida_serial !== 1'b0) errs++;
                for (int b = 0; b < 7; b++) begin
                    repeat (BAUD) @(negedge clock);
                    d[b] = saida_serial;
                end
                repeat (BAUD) @(negedge clock);
                p = saida_serial;
                repeat (BAUD) @(negedge clock);
                s = saida_serial;
                if (p !== ^d) errs++;
                if (s !== 1'b1) errs++;
                f = {f[87:0], 1'b0, d};
            end
        end
        check_val($sformatf("%s_lost", tag), 128'(lost), 128'(0));
        check_val($sformatf("%s_fmt", tag), 128'(errs), 128'(0));
        check_val($sformatf("%s_frame", tag), 128'(f), 128'(exp_frame()));
        n = 0;
        while (pronto !== 1'b1 && n < 4 * BAUD) begin
            @(negedge clock);
            n++;
        end
        check_val($sformatf("%s_pronto", tag), 128'(pronto), 128'(1));
        @(negedge clock);
        check_val($sformatf("%s_pronto_w", tag), 128'(pronto), 128'(0));
    endtask

    task automatic run_cycle(input int mode, input int bound, input string tag);
        if (pre_hi) echo1 = 1'b1;
        start_meas(mode, bound, tag);
        drive_echoes();
        get_frame(tag);
        clear_echoes();
    endtask

    task automatic watch_idle(input string tag);
        int hits;
        hits = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (trigger1 !== 1'b0) hits++;
        end
        check_val(tag, 128'(hits), 128'(0));
    endtask

    initial begin
        ligar = 1'b1;
        repeat (3) @(negedge clock);
        check_val("rst_trig", 128'({trigger1, trigger2, trigger3}), 128'(0));
        check_val("rst_ser", 128'(saida_serial), 128'(1));
        check_val("rst_pronto", 128'(pronto), 128'(0));
        reset = 1'b1;
        @(negedge clock);
        ligar = 1'b0;
        set_cfg(0, 0, 0, 1, 1, 1);
        start_meas(2, 10, "boot");
        drive_echoes();
        get_frame("boot");

        set_cfg(400, 400, 400, 30, 30, 30);
        run_cycle(0, 10, "d100");
        set_cfg(399, 295, 299, 10, 50, 90);
        run_cycle(0, 10, "dmix");
        set_cfg(1, 2, 5, 3, 3, 3);
        run_cycle(0, 10, "dsmall");
        pre_hi = 1'b1;
        set_cfg(198, 100, 4100, 5, 20, 5);
        run_cycle(0, 10, "prehi");

        for (int r = 0; r < 5; r++) begin
            set_rand();
            run_cycle(r % 2, 200, $sformatf("rnd%0d", r));
        end

        set_rand();
        start_meas(0, 10, "ltx");
        drive_echoes();
        fork
            get_frame("ltx");
            begin
                t = 0;
                while (saida_serial !== 1'b0 && t < TMO + 200) begin
                    @(negedge clock);
                    t++;
                end
                repeat (30 * BAUD) @(negedge clock);
                ligar = 1'b1;
                @(negedge clock);
                ligar = 1'b0;
            end
        join
        clear_echoes();
        set_cfg(0, 0, 0, 1, 1, 1);
        run_cycle(2, 4, "ltx2");

        set_cfg(123, 456, 789, 7, 8, 9);
        run_cycle(1, 200, "rxL");
        send_rx(7'h2A, 1'b0);
        watch_idle("rx2A_idle");
`ifdef RX_PARITY_CHECK_EN
        send_rx(7'h4C, 1'b1);
        watch_idle("rxpar_idle");
`endif

        set_cfg(300, 310, 320, 4, 4, 4);
        start_meas(0, 10, "rtx");
        drive_echoes();
        t = 0;
        while (saida_serial !== 1'b0 && t < TMO + 200) begin
            @(negedge clock);
            t++;
        end
        repeat (200) @(negedge clock);
        reset = 1'b0;
        #1;
        check_val("rtx_ser", 128'(saida_serial), 128'(1));
        check_val("rtx_trig", 128'({trigger1, trigger2, trigger3}), 128'(0));
        check_val("rtx_pronto", 128'(pronto), 128'(0));
        @(negedge clock);
        reset = 1'b1;
        clear_echoes();
        watch_idle("rtx_idle");
        set_rand();
        run_cycle(0, 10, "post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/roberto.md
Name: roberto

Overview:
- Three-channel ultrasonic ranging controller with a 7E1 UART link.
- A start request fires the trigger pulse on all three HC-SR04-style sonars at once. It then measures each echo width, converts it to whole centimetres (rounded to nearest) as 3-digit BCD, and transmits the three readings as an ASCII frame on saida_serial.
- The RX line accepts a remote start command.
- Top-level block of the sonar subsystem, clocked at 50 MHz.

Parameters:
- CLK_PER_CM, 2941, clocks per centimetre of echo width (58.82 us at 50 MHz).
- TRIG_CLKS, 500, trigger pulse width in clocks (10 us).
- TIMEOUT_CLKS, 1500000, echo window measured from trigger fall (30 ms).
- BAUD_DIV, 434, clocks per UART bit (115200 baud).

Ports:
- clock  in  1  system clock, 50 MHz, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ligar  in  1  start request, level-sampled every clock.
- echo1  in  1  sonar 1 echo.
- echo2  in  1  sonar 2 echo.
- echo3  in  1  sonar 3 echo.
- RX  in  1  UART receive line, idle high.
- trigger1  out  1  sonar 1 trigger.
- trigger2  out  1  sonar 2 trigger.
- trigger3  out  1  sonar 3 trigger.
- saida_serial  out  1  UART transmit line, idle high.
- pronto  out  1  one-clock pulse at the end of a measure+transmit cycle.

Behaviour:
- Reset (reset=0, asynchronous) forces all of the following:
  - trigger1..3=0, saida_serial=1, pronto=0.
  - FSM=IDLE, start-pending flag cleared, distances set to 000.
- Reset asserted mid-cycle aborts the cycle immediately with the same reset values.
- Start-pending flag:
  - Set on any clock where ligar=1, in any state.
  - Also set by a valid RX command character.
  - Cleared when the FSM leaves IDLE.
  - A request made while busy is therefore honoured right after the current cycle, not lost.
- FSM states:
  - IDLE: on the clock the pending flag is seen set, go to TRIG.
  - TRIG: trigger1..3=1 for exactly TRIG_CLKS clocks, then WAIT_ECHO.
  - WAIT_ECHO: per-channel measurement runs (see below). Exit when all three channels are done or the timeout counter reaches TIMEOUT_CLKS.
  - TX: send the 12-character frame.
  - DONE: pronto=1 for one clock, then IDLE.
- Per-channel measurement:
  - Wait for echo high; an echo already high at trigger fall counts as started.
  - Count while high; the channel is done on echo fall.
  - Echo is synchronised through 2 flops before use.
- Conversion:
  - Sub-counter preloaded to CLK_PER_CM/2 (1470).
  - Sub-counter increments every clock while echo is high.
  - On reaching CLK_PER_CM it wraps to 0 and the 3-digit BCD cm counter increments.
  - Result: cm = floor((clocks + 1470) / 2941), i.e. round to nearest.
  - BCD counter saturates at 999.
  - A channel not done at timeout (no echo, or echo still high) reports 999.
- Frame format:
  - ASCII "d1d1d1,d2d2d2,d3d3d3#", 12 characters, hundreds digit first.
  - Digits are 0x30+BCD, ',' = 0x2C, '#' = 0x23.
- UART TX character format:
  - Start bit 0, then 7 data bits LSB first, then even parity bit (XOR of data), then stop bit 1.
  - Each bit lasts BAUD_DIV clocks; no idle gap between characters.
- UART RX:
  - 2-flop synchroniser.
  - Falling edge while idle starts a frame; each bit is sampled at mid-bit, BAUD_DIV/2 clocks after its start.
  - Start bit sampled high: discard and return to idle.
  - Stop bit sampled low: framing error, discard.
  - Character 0x4C ('L') sets start-pending; all other characters are ignored.
  - RX runs independently of the main FSM, including during TX.

Optional Feature:
- Macro: RX_PARITY_CHECK_EN.
- Defined: a received character whose parity bit differs from the even parity of its 7 data bits is discarded.
- Undefined: the RX parity bit is sampled and ignored.
- TX always sends even parity regardless of the macro.

Test Plan:
- Reset release with ligar held high, no echoes → triggers high for 500 clocks; timeout; frame "999,999,999#"; pronto pulse; a further ligar pulse is honoured afterwards.
- ligar pulse; all echoes high 5882 us starting 400 us after trigger → frame "100,100,100#", then pronto.
- Echo widths 5899 / 4353 / 4399 us on channels 1/2/3 → frame "100,074,075#".
- ligar pulsed during TX → a second cycle starts immediately after pronto, with no second ligar needed.
- RX sends 'L' (0x4C) with even parity while IDLE → measurement starts. RX sends 0x2A → no effect. With RX_PARITY_CHECK_EN defined, 'L' with bad parity → no effect.
- Reset asserted during TX → saida_serial=1 and triggers=0 immediately; the next ligar produces a full, correct frame.
